// File: rtl/delay_mem_scheduler.sv
// delay_mem_scheduler
//   Shares one single-port delay RAM among NCH sample streams. A round-robin
//   arbiter accepts at most one sample per cycle. The accepted sample is
//   written into its channel's RAM segment, and the word it overwrites is
//   returned one cycle later. That word is the sample pushed len[c] pushes
//   earlier on the same channel.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   req_valid  : per-channel sample valid             [NCH]
//   req_data   : per-channel samples, ch c at [c*DW +: DW]
//   req_ready  : one-hot (or zero) grant, combinational
//   len_wr     : configuration write strobe
//   len_ch     : channel to configure
//   len_val    : new delay, clamped to [MIN_LEN, SEG]
//   out_valid  : delayed sample present (1 cycle after handshake)
//   out_ch     : channel of the delayed sample
//   out_data   : delayed sample
//   out_warm   : delayed sample is genuine history
//
// Build option
//   DELAY_SCHED_COLD_ZERO_EN : when defined, out_data reads 0 on cold beats.
//   When not defined, the raw RAM word is passed through and only out_warm
//   flags validity.
module delay_mem_scheduler #(
  parameter int DW      = 8,
  parameter int NCH     = 4,
  parameter int SEG     = 16,
  parameter int MIN_LEN = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NCH-1:0]             req_valid,
  input  logic [NCH*DW-1:0]          req_data,
  output logic [NCH-1:0]             req_ready,
  input  logic                       len_wr,
  input  logic [$clog2(NCH)-1:0]     len_ch,
  input  logic [$clog2(SEG+1)-1:0]   len_val,
  output logic                       out_valid,
  output logic [$clog2(NCH)-1:0]     out_ch,
  output logic [DW-1:0]              out_data,
  output logic                       out_warm
);

  localparam int CW = $clog2(NCH);
  localparam int PW = $clog2(SEG);
  localparam int LW = $clog2(SEG + 1);

  // Per-channel state
  logic [LW-1:0] len_reg  [NCH];
  logic [PW-1:0] ptr_reg  [NCH];
  logic [LW-1:0] fill_reg [NCH];

  logic [NCH-1:0] cfg_hit;
  logic [NCH-1:0] eligible;
  logic [NCH-1:0] grant;
  logic [CW-1:0]  grant_idx;
  logic [CW-1:0]  last_reg;
  logic           push;
  logic [LW-1:0]  len_clamped;

  // Configuration value clamped into the legal delay range
  always_comb begin
    len_clamped = len_val;
    if (len_val < LW'(MIN_LEN)) begin
      len_clamped = LW'(MIN_LEN);
    end else if (len_val > LW'(SEG)) begin
      len_clamped = LW'(SEG);
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      // A channel being reconfigured sits out arbitration that cycle.
      // An out-of-range len_ch never matches, so such a write is ignored.
      assign cfg_hit[gi]  = len_wr && (len_ch == CW'(gi));
      assign eligible[gi] = rst_n && req_valid[gi] && !cfg_hit[gi];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          len_reg[gi]  <= LW'(SEG);
          ptr_reg[gi]  <= '0;
          fill_reg[gi] <= '0;
        end else if (cfg_hit[gi]) begin
          len_reg[gi]  <= len_clamped;
          ptr_reg[gi]  <= '0;
          fill_reg[gi] <= '0;
        end else if (grant[gi]) begin
          if (LW'(ptr_reg[gi]) >= len_reg[gi] - LW'(1)) begin
            ptr_reg[gi] <= '0;
          end else begin
            ptr_reg[gi] <= ptr_reg[gi] + PW'(1);
          end
          if (fill_reg[gi] < len_reg[gi]) begin
            fill_reg[gi] <= fill_reg[gi] + LW'(1);
          end
        end
      end
    end
  endgenerate

  // Round-robin: first eligible channel after the last one granted
  always_comb begin
    logic [CW-1:0] cand;
    logic          found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = CW'((int'(last_reg) + i) % NCH);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign req_ready = grant;
  assign push      = |grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_reg <= CW'(NCH - 1);
    end else if (push) begin
      last_reg <= grant_idx;
    end
  end

  // Shared RAM: segment c occupies addresses {c, 0..SEG-1}
  logic [DW-1:0]    mem [NCH*SEG];
  logic [CW+PW-1:0] addr;
  logic [DW-1:0]    wr_data;
  logic [DW-1:0]    rd_reg;
  logic             sel_warm;

  assign addr     = {grant_idx, ptr_reg[grant_idx]};
  assign wr_data  = req_data[grant_idx*DW +: DW];
  assign sel_warm = (fill_reg[grant_idx] == len_reg[grant_idx]);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[addr] <= wr_data;
    end
  end

  // Read-before-write: the overwritten word is the delayed sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_reg <= '0;
    end else if (push) begin
      rd_reg <= mem[addr];
    end
  end

  logic          out_valid_reg;
  logic [CW-1:0] out_ch_reg;
  logic          out_warm_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      out_warm_reg  <= 1'b0;
    end else begin
      out_valid_reg <= push;
      if (push) begin
        out_ch_reg   <= grant_idx;
        out_warm_reg <= sel_warm;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_ch    = out_ch_reg;
  assign out_warm  = out_warm_reg;

`ifdef DELAY_SCHED_COLD_ZERO_EN
  assign out_data = out_warm_reg ? rd_reg : '0;
`else
  assign out_data = rd_reg;
`endif

endmodule

// File: tb/tb_delay_mem_scheduler.sv
module tb_delay_mem_scheduler;

  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int SEG = 16;
  localparam int MIN_LEN = 2;
  localparam int CW  = 2;
  localparam int LW  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    req_valid;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    req_ready;
  logic              len_wr;
  logic [CW-1:0]     len_ch;
  logic [LW-1:0]     len_val;
  logic              out_valid;
  logic [CW-1:0]     out_ch;
  logic [DW-1:0]     out_data;
  logic              out_warm;

  always #5 clk = ~clk;

  delay_mem_scheduler #(.DW(DW), .NCH(NCH), .SEG(SEG), .MIN_LEN(MIN_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .len_wr(len_wr), .len_ch(len_ch), .len_val(len_val),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .out_warm(out_warm)
  );

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    bit            warm;
    bit            chk;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: per-channel delay and history of samples since last
  // reset/configuration; round-robin pointer.
  int            mlen [NCH];
  logic [DW-1:0] hist [NCH][$];
  int            last_gnt;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      mlen[c] = SEG;
      hist[c].delete();
    end
    last_gnt = NCH - 1;
  endfunction

  function automatic int rr_pick(logic [NCH-1:0] v, logic wr, logic [CW-1:0] ch, logic rn);
    if (!rn) return -1;
    for (int i = 1; i <= NCH; i++) begin
      int c;
      c = (last_gnt + i) % NCH;
      if (v[c] && !(wr && int'(ch) == c)) return c;
    end
    return -1;
  endfunction

  // One clock cycle of stimulus; entered and left at posedge+1
  task automatic step(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d,
                      input logic wr, input logic [CW-1:0] ch,
                      input logic [LW-1:0] val, input logic rn);
    int g;
    logic [NCH-1:0] exp_rdy;
    req_valid = v; req_data = d; len_wr = wr; len_ch = ch; len_val = val; rst_n = rn;
    g = rr_pick(v, wr, ch, rn);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== exp_rdy) begin
      bad++;
      $display("FAIL req_ready: got=%b want=%b t=%0t", req_ready, exp_rdy, $time);
    end
    @(posedge clk);
    #1;
    if (!rn) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        exp_t e;
        logic [DW-1:0] s;
        s = d[g*DW +: DW];
        e.ch   = g;
        e.warm = (hist[g].size() >= mlen[g]);
        if (e.warm) begin
          e.data = hist[g][hist[g].size() - mlen[g]];
          e.chk  = 1'b1;
        end else begin
          e.data = '0;
`ifdef DELAY_SCHED_COLD_ZERO_EN
          e.chk  = 1'b1;
`else
          e.chk  = 1'b0;
`endif
        end
        exp_q.push_back(e);
        hist[g].push_back(s);
        if (hist[g].size() > SEG) void'(hist[g].pop_front());
        last_gnt = g;
      end
      if (wr && int'(ch) < NCH) begin
        int nl;
        nl = int'(val);
        if (nl < MIN_LEN) nl = MIN_LEN;
        if (nl > SEG) nl = SEG;
        mlen[ch] = nl;
        hist[ch].delete();
      end
    end
  endtask

  // Monitor: every output beat must match the oldest expected response
  always @(negedge clk) begin
    if (rst_n !== 1'bx) begin
      total++;
      if (out_valid !== (exp_q.size() != 0)) begin
        bad++;
        $display("FAIL out_valid: got=%b want=%0d t=%0t", out_valid, exp_q.size() != 0, $time);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_valid === 1'b1) begin
          total++;
          if (out_ch !== CW'(e.ch) || out_warm !== e.warm || (e.chk && out_data !== e.data)) begin
            bad++;
            $display("FAIL beat: got ch=%0d warm=%b data=%0h want ch=%0d warm=%b data=%0h t=%0t",
                     out_ch, out_warm, out_data, e.ch, e.warm, e.data, $time);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [NCH*DW-1:0] rnd_data();
    return (NCH*DW)'($urandom);
  endfunction

  initial begin
    model_reset();
    rst_n = 1'b0; req_valid = '0; req_data = '0; len_wr = 1'b0; len_ch = '0; len_val = '0;
    @(posedge clk); #1;
    // Reset state
    step('1, rnd_data(), 1'b0, 2'd0, 5'd0, 1'b0);
    step('1, rnd_data(), 1'b0, 2'd0, 5'd0, 1'b0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ch",    32'(out_ch),    32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_warm",  32'(out_warm),  32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // Single channel delay, len 16, samples 1..40
    for (int k = 1; k <= 40; k++) begin
      logic [NCH*DW-1:0] d;
      d = rnd_data();
      d[DW-1:0] = DW'(k);
      step(4'b0001, d, 1'b0, 2'd0, 5'd0, 1'b1);
    end
    step('0, '0, 1'b0, 2'd0, 5'd0, 1'b1);

    // Round-robin fairness
    for (int k = 0; k < 8; k++) step(4'b1111, rnd_data(), 1'b0, 2'd0, 5'd0, 1'b1);

    // Length reconfiguration on channel 1 while it requests
    for (int k = 0; k < 20; k++) step(4'b0010, rnd_data(), 1'b0, 2'd0, 5'd0, 1'b1);
    step(4'b0010, rnd_data(), 1'b1, 2'd1, 5'd3, 1'b1);
    for (int k = 0; k < 8; k++) step(4'b0010, rnd_data(), 1'b0, 2'd0, 5'd0, 1'b1);

    // Clamping low and high
    step('0, '0, 1'b1, 2'd2, 5'd0, 1'b1);
    for (int k = 0; k < 8; k++) step(4'b0100, rnd_data(), 1'b0, 2'd0, 5'd0, 1'b1);
    step('0, '0, 1'b1, 2'd2, 5'd31, 1'b1);
    for (int k = 0; k < 20; k++) step(4'b0100, rnd_data(), 1'b0, 2'd0, 5'd0, 1'b1);

    // Reset mid-stream on channels 0 and 2
    for (int k = 0; k < 6; k++) step(4'b0101, rnd_data(), 1'b0, 2'd0, 5'd0, 1'b1);
    step(4'b0101, rnd_data(), 1'b0, 2'd0, 5'd0, 1'b0);
    for (int k = 0; k < 40; k++) step(4'b0101, rnd_data(), 1'b0, 2'd0, 5'd0, 1'b1);

    // Idle gaps on channel 3, len 5
    step('0, '0, 1'b1, 2'd3, 5'd5, 1'b1);
    for (int k = 0; k < 80; k++) begin
      logic [NCH-1:0] v;
      v = '0;
      v[3] = ($urandom_range(0, 2) == 0);
      step(v, rnd_data(), 1'b0, 2'd0, 5'd0, 1'b1);
    end

    // Random mix with occasional reconfiguration
    for (int k = 0; k < 400; k++) begin
      step(NCH'($urandom), rnd_data(), ($urandom_range(0, 15) == 0),
           CW'($urandom), LW'($urandom), 1'b1);
    end

    for (int k = 0; k < 3; k++) step('0, '0, 1'b0, 2'd0, 5'd0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
